payment_controller: RTL

PAYMENT_CONTROLLER -- requirements
Module: payment_controller

---
 rtl/payment_controller.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/payment_controller.sv
// payment_controller -- coin-operated car-wash payment FSM.
//
// Accumulates coin credit, charges a single or double wash price on start,
// launches the washing machine with a one-cycle coin_in pulse, waits for the
// wash_done rising edge, and refunds remaining credit on cancel. All outputs
// are registered.
//
// Optional build macro: COIN_SYNC_EN -- when defined, coin_strobe/coin_value
// pass through a two-stage register pipeline before the FSM, so coin-to-credit
// latency is 3 cycles instead of 1.
//
// Ports:
//   clk, rst       clock (rising edge) and asynchronous active-high reset
//   coin_strobe    one-cycle coin pulse qualifying coin_value (01=1,10=2,11=5)
//   start_btn      start request, double_sel sampled with it
//   cancel_btn     refund request (wins over start)
//   wash_done      level from the machine, rising edge ends the wash
//   coin_in        one-cycle launch pulse to the machine
//   double_wash    double-wash selection held for the duration of the wash
//   credit         current credit (4-bit, never wraps)
//   busy           high in LAUNCH and RUNNING
//   coin_reject    one-cycle pulse for a returned coin
//   start_err      one-cycle pulse for a refused start
//   refund_pulse   one-cycle refund strobe, refund_amount valid with it
module payment_controller #(
  parameter int unsigned PRICE_SINGLE = 4,
  parameter int unsigned PRICE_DOUBLE = 6,
  parameter int unsigned CREDIT_MAX   = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_strobe,
  input  logic [1:0] coin_value,
  input  logic       start_btn,
  input  logic       double_sel,
  input  logic       cancel_btn,
  input  logic       wash_done,
  output logic       coin_in,
  output logic       double_wash,
  output logic [3:0] credit,
  output logic       busy,
  output logic       coin_reject,
  output logic       start_err,
  output logic       refund_pulse,
  output logic [3:0] refund_amount
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_LAUNCH  = 2'd2;
  localparam logic [1:0] S_RUNNING = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] credit_q, credit_d;
  logic       double_q, double_d;
  logic       coin_in_q, coin_in_d;
  logic       busy_q, busy_d;
  logic       reject_q, reject_d;
  logic       err_q, err_d;
  logic       refund_q, refund_d;
  logic [3:0] amt_q, amt_d;
  logic       wd_q;

  // Coin source seen by the FSM (direct or pipelined)
  logic       coin_stb;
  logic [1:0] coin_val;

`ifdef COIN_SYNC_EN
  logic       stb1_q, stb2_q;
  logic [1:0] val1_q, val2_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stb1_q <= 1'b0;
      stb2_q <= 1'b0;
      val1_q <= '0;
      val2_q <= '0;
    end else begin
      stb1_q <= coin_strobe;
      val1_q <= coin_value;
      stb2_q <= stb1_q;
      val2_q <= val1_q;
    end
  end

  assign coin_stb = stb2_q;
  assign coin_val = val2_q;
`else
  assign coin_stb = coin_strobe;
  assign coin_val = coin_value;
`endif

  logic [3:0] coin_units;
  logic [4:0] sum;
  logic [3:0] price;
  logic       in_wash;
  logic       coin_ok;
  logic       wd_rise;

  always_comb begin
    case (coin_val)
      2'b01:   coin_units = 4'd1;
      2'b10:   coin_units = 4'd2;
      2'b11:   coin_units = 4'd5;
      default: coin_units = 4'd0;
    endcase
    // 5-bit sum so the ceiling check cannot be fooled by 4-bit wrap
    sum     = {1'b0, credit_q} + {1'b0, coin_units};
    price   = double_sel ? 4'(PRICE_DOUBLE) : 4'(PRICE_SINGLE);
    in_wash = (state_q == S_LAUNCH) || (state_q == S_RUNNING);
    coin_ok = coin_stb && (coin_val != 2'b00) && !in_wash && !start_btn &&
              !cancel_btn && (sum <= 5'(CREDIT_MAX));
    // wd_q tracks wash_done every cycle, so a level already high on entry
    // into RUNNING never looks like an edge
    wd_rise = wash_done && !wd_q;

    state_d   = state_q;
    credit_d  = credit_q;
    double_d  = double_q;
    coin_in_d = 1'b0;
    reject_d  = coin_stb && !coin_ok;
    err_d     = 1'b0;
    refund_d  = 1'b0;
    amt_d     = '0;

    case (state_q)
      S_IDLE: begin
        if (cancel_btn) begin
          // nothing to refund; cancel still suppresses start
        end else if (start_btn) begin
          err_d = 1'b1;
        end else if (coin_ok) begin
          credit_d = sum[3:0];
          state_d  = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (cancel_btn) begin
          refund_d = 1'b1;
          amt_d    = credit_q;
          credit_d = '0;
          state_d  = S_IDLE;
        end else if (start_btn) begin
          if (credit_q >= price) begin
            credit_d  = credit_q - price;
            double_d  = double_sel;
            coin_in_d = 1'b1;
            state_d   = S_LAUNCH;
          end else begin
            err_d = 1'b1;
          end
        end else if (coin_ok) begin
          credit_d = sum[3:0];
        end
      end
      S_LAUNCH: begin
        state_d = S_RUNNING;
      end
      default: begin
        if (wd_rise) begin
          double_d = 1'b0;
          state_d  = (credit_q != '0) ? S_COLLECT : S_IDLE;
        end
      end
    endcase

    busy_d = (state_d == S_LAUNCH) || (state_d == S_RUNNING);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      credit_q  <= '0;
      double_q  <= 1'b0;
      coin_in_q <= 1'b0;
      busy_q    <= 1'b0;
      reject_q  <= 1'b0;
      err_q     <= 1'b0;
      refund_q  <= 1'b0;
      amt_q     <= '0;
      wd_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      credit_q  <= credit_d;
      double_q  <= double_d;
      coin_in_q <= coin_in_d;
      busy_q    <= busy_d;
      reject_q  <= reject_d;
      err_q     <= err_d;
      refund_q  <= refund_d;
      amt_q     <= amt_d;
      wd_q      <= wash_done;
    end
  end

  assign coin_in       = coin_in_q;
  assign double_wash   = double_q;
  assign credit        = credit_q;
  assign busy          = busy_q;
  assign coin_reject   = reject_q;
  assign start_err     = err_q;
  assign refund_pulse  = refund_q;
  assign refund_amount = amt_q;

endmodule
